// File: rtl/bounce_gen.sv
// rtl/bounce_gen.sv - switch bounce generator driven by a 16-bit Galois LFSR
//
// Purpose: turns a clean switch level into a bouncy one for exercising a
// debouncer. A level change on sw_in (with en=1) opens a window of exactly
// BOUNCE_LEN cycles. Inside the window sw_out flips after pseudo-random
// segments of 1..2^SEG_W cycles. When the window closes, sw_out settles on the
// most recent sw_in level.
//
// Ports:
//   clk      in   1  clock, rising edge
//   reset    in   1  asynchronous, active-low
//   sw_in    in   1  clean switch level (synchronous to clk)
//   en       in   1  1 = inject bounce, 0 = registered pass-through
//   sw_out   out  1  bouncy switch level (registered)
//   busy     out  1  burst window in progress
//   toggles  out  8  sw_out transitions in current/last burst, saturating
`timescale 1ns/1ps
module bounce_gen #(
    parameter int          BOUNCE_LEN = 1000000,
    parameter int          SEG_W      = 8,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_in,
    input  logic       en,
    output logic       sw_out,
    output logic       busy,
    output logic [7:0] toggles
);

    localparam int               WIN_W     = (BOUNCE_LEN > 1) ? $clog2(BOUNCE_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(BOUNCE_LEN - 1);
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [15:0]      LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic {
        S_IDLE,
        S_BOUNCE
    } state_t;

    state_t           r_state;
    logic [15:0]      r_lfsr;
    logic [WIN_W-1:0] r_win_cnt;
    logic [SEG_W-1:0] r_seg_cnt;
    logic             r_target;
    logic             r_sw_out;
    logic [7:0]       r_toggles;

    logic [15:0]      w_lfsr_next;
    logic [SEG_W-1:0] w_seg_load;
    logic [7:0]       w_tog_inc;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_seg_load  = r_lfsr[SEG_W-1:0];
    assign w_tog_inc   = (r_toggles == 8'hFF) ? r_toggles : r_toggles + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_lfsr    <= LFSR_INIT;
            r_win_cnt <= '0;
            r_seg_cnt <= '0;
            r_target  <= 1'b0;
            r_sw_out  <= 1'b0;
            r_toggles <= 8'd0;
        end else begin
            // The LFSR free-runs so segment lengths depend on absolute timing.
            r_lfsr <= w_lfsr_next;
            case (r_state)
                S_IDLE: begin
                    if (!en) begin
                        r_sw_out <= sw_in;
                    end else if (sw_in != r_sw_out) begin
                        r_sw_out  <= ~r_sw_out;
                        r_target  <= sw_in;
                        r_win_cnt <= WIN_LAST;
                        r_seg_cnt <= w_seg_load;
                        r_toggles <= 8'd1;
                        r_state   <= S_BOUNCE;
                    end
                end
                S_BOUNCE: begin
                    // Latest input level wins; the window itself never restarts.
                    r_target <= sw_in;
                    if (!en) begin
                        // Abort: snap to the input, keep the toggle count.
                        r_sw_out  <= sw_in;
                        r_win_cnt <= '0;
                        r_seg_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else if (r_win_cnt == '0) begin
                        r_sw_out <= r_target;
                        r_state  <= S_IDLE;
                        if (r_sw_out != r_target) begin
                            r_toggles <= w_tog_inc;
                        end
                    end else begin
                        r_win_cnt <= r_win_cnt - 1'b1;
                        if (r_seg_cnt == '0) begin
                            r_sw_out  <= ~r_sw_out;
                            r_seg_cnt <= w_seg_load;
                            r_toggles <= w_tog_inc;
                        end else begin
                            r_seg_cnt <= r_seg_cnt - 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sw_out  = r_sw_out;
    assign busy    = (r_state == S_BOUNCE);
    assign toggles = r_toggles;

endmodule
